// File: rtl/xgs_tpg_pkg.sv
// Shared types and constants for the multi-lane test pattern generator.
package xgs_tpg_pkg;

   typedef enum logic [1:0] {
      TPG_RAMP  = 2'd0,
      TPG_CONST = 2'd1,
      TPG_WALK1 = 2'd2,
      TPG_LFSR  = 2'd3
   } tpg_mode_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LINE = 2'd1,
      ST_GAP  = 2'd2,
      ST_END  = 2'd3
   } tpg_state_e;

   // Maximal-length Fibonacci feedback masks, bit (t-1) set for tap t
   localparam logic [15:0] LFSR_TAPS [8:16] = '{
      16'h00B8,   // 8:  8,6,5,4
      16'h0110,   // 9:  9,5
      16'h0240,   // 10: 10,7
      16'h0500,   // 11: 11,9
      16'h0829,   // 12: 12,6,4,1
      16'h100D,   // 13: 13,4,3,1
      16'h2015,   // 14: 14,5,3,1
      16'h6000,   // 15: 15,14
      16'hD008    // 16: 16,15,13,4
   };

endpackage

// File: rtl/xgs_tpg_lane_gen.sv
// Combinational pixel generator: all lanes of one beat plus the LFSR state
// after the beat.
module xgs_tpg_lane_gen
   import xgs_tpg_pkg::*;
#(
   parameter int NUM_LANES   = 4,
   parameter int PIXEL_WIDTH = 12
) (
   input  tpg_mode_e                        mode,
   input  logic [PIXEL_WIDTH-1:0]           seed,
   input  logic [PIXEL_WIDTH-1:0]           pix_base,
   input  logic [3:0]                       walk_base,
   input  logic [PIXEL_WIDTH-1:0]           lfsr_state,
   output logic [NUM_LANES*PIXEL_WIDTH-1:0] lane_data,
   output logic [PIXEL_WIDTH-1:0]           lfsr_next
);

   localparam logic [PIXEL_WIDTH-1:0] TAP_MASK = PIXEL_WIDTH'(LFSR_TAPS[PIXEL_WIDTH]);

   always_comb begin
      logic [PIXEL_WIDTH-1:0] lfsr_v;
      int                     pos;
      lane_data = '0;
      lfsr_v    = lfsr_state;
      pos       = 0;
      for (int k = 0; k < NUM_LANES; k++) begin
         pos = (int'(walk_base) + k) % PIXEL_WIDTH;
         case (mode)
            TPG_RAMP:  lane_data[k*PIXEL_WIDTH +: PIXEL_WIDTH] = seed + pix_base + PIXEL_WIDTH'(k);
            TPG_CONST: lane_data[k*PIXEL_WIDTH +: PIXEL_WIDTH] = seed;
            TPG_WALK1: lane_data[k*PIXEL_WIDTH +: PIXEL_WIDTH] = PIXEL_WIDTH'(1) << pos;
            TPG_LFSR:  lane_data[k*PIXEL_WIDTH +: PIXEL_WIDTH] = lfsr_v;
            default:   lane_data[k*PIXEL_WIDTH +: PIXEL_WIDTH] = '0;
         endcase
         // lane k carries the state after k steps; the chain keeps advancing
         lfsr_v = {lfsr_v[PIXEL_WIDTH-2:0], ^(lfsr_v & TAP_MASK)};
      end
      lfsr_next = lfsr_v;
   end

endmodule

// File: rtl/xgs_tpg_multilane.sv
// Multi-lane video test pattern generator with frame/line sequencing.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   ST_IDLE | waiting for start, outputs quiet
//   ST_LINE | presenting beats of the current line
//   ST_GAP  | idle cycles between lines, tvalid low
//   ST_END  | one-cycle done pulse, then back to idle
module xgs_tpg_multilane
   import xgs_tpg_pkg::*;
#(
   parameter int NUM_LANES      = 4,
   parameter int PIXEL_WIDTH    = 12,
   parameter int LINE_CNT_WIDTH = 12
) (
   input  logic                             sclk,
   input  logic                             srst,
   input  logic                             start,
   input  logic                             abort,
   input  logic [1:0]                       mode,
   input  logic [PIXEL_WIDTH-1:0]           seed,
   input  logic [LINE_CNT_WIDTH-1:0]        line_beats,
   input  logic [LINE_CNT_WIDTH-1:0]        frame_lines,
   input  logic [7:0]                       gap_cycles,
   output logic                             tvalid,
   input  logic                             tready,
   output logic [NUM_LANES*PIXEL_WIDTH-1:0] tdata,
   output logic                             tuser,
   output logic                             tlast,
   output logic                             busy,
   output logic                             done
);

   tpg_state_e                    state, state_nxt;
   tpg_mode_e                     mode_q;
   logic [PIXEL_WIDTH-1:0]        seed_q;
   logic [LINE_CNT_WIDTH-1:0]     line_beats_q;
   logic [7:0]                    gap_q;
   logic [LINE_CNT_WIDTH-1:0]     beat_rem;
   logic [LINE_CNT_WIDTH-1:0]     line_rem;
   logic [7:0]                    gap_rem;
   logic [PIXEL_WIDTH-1:0]        pix_base;
   logic [3:0]                    walk_base;
   logic [3:0]                    walk_nxt;
   logic [PIXEL_WIDTH-1:0]        lfsr_q;
   logic [PIXEL_WIDTH-1:0]        lfsr_next;
   logic                          sof_q;
   logic [NUM_LANES*PIXEL_WIDTH-1:0] lane_data;
   logic                          xfer;
   logic                          last_beat;
   logic                          last_line;

   assign xfer      = (state == ST_LINE) && tready;
   assign last_beat = (beat_rem == '0);
   assign last_line = (line_rem == '0);
   assign walk_nxt  = 4'((int'(walk_base) + NUM_LANES) % PIXEL_WIDTH);

   always_ff @(posedge sclk) begin
      if (srst) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (start) state_nxt = ST_LINE;
         ST_LINE: begin
            if (abort) state_nxt = ST_END;
            else if (xfer && last_beat) begin
               if (last_line)           state_nxt = ST_END;
               else if (gap_q == 8'd0)  state_nxt = ST_LINE;
               else                     state_nxt = ST_GAP;
            end
         end
         ST_GAP: begin
            if (abort)                 state_nxt = ST_END;
            else if (gap_rem == 8'd0)  state_nxt = ST_LINE;
         end
         ST_END:  state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge sclk) begin
      if (srst) begin
         mode_q       <= TPG_RAMP;
         seed_q       <= '0;
         line_beats_q <= '0;
         gap_q        <= '0;
         beat_rem     <= '0;
         line_rem     <= '0;
         gap_rem      <= '0;
         pix_base     <= '0;
         walk_base    <= '0;
         lfsr_q       <= '0;
         sof_q        <= 1'b0;
      end else begin
         if ((state == ST_IDLE) && start) begin
            mode_q       <= tpg_mode_e'(mode);
            seed_q       <= seed;
            line_beats_q <= line_beats;
            gap_q        <= gap_cycles;
            beat_rem     <= line_beats;
            line_rem     <= frame_lines;
            gap_rem      <= '0;
            pix_base     <= '0;
            walk_base    <= '0;
            // an all-zero state would lock the LFSR
            lfsr_q       <= (seed == '0) ? '1 : seed;
            sof_q        <= 1'b1;
         end
         if (xfer) begin
            pix_base  <= pix_base + PIXEL_WIDTH'(NUM_LANES);
            walk_base <= walk_nxt;
            lfsr_q    <= lfsr_next;
            sof_q     <= 1'b0;
            if (last_beat) begin
               beat_rem <= line_beats_q;
               if (!last_line) begin
                  line_rem <= line_rem - LINE_CNT_WIDTH'(1);
                  gap_rem  <= gap_q - 8'd1;
               end
            end else begin
               beat_rem <= beat_rem - LINE_CNT_WIDTH'(1);
            end
         end
         if ((state == ST_GAP) && (gap_rem != 8'd0)) gap_rem <= gap_rem - 8'd1;
      end
   end

   xgs_tpg_lane_gen #(
      .NUM_LANES   (NUM_LANES),
      .PIXEL_WIDTH (PIXEL_WIDTH)
   ) u_lane_gen (
      .mode       (mode_q),
      .seed       (seed_q),
      .pix_base   (pix_base),
      .walk_base  (walk_base),
      .lfsr_state (lfsr_q),
      .lane_data  (lane_data),
      .lfsr_next  (lfsr_next)
   );

   always_comb begin
      tvalid = (state == ST_LINE);
      tdata  = tvalid ? lane_data : '0;
      tuser  = tvalid && sof_q;
      tlast  = tvalid && last_beat;
      busy   = (state == ST_LINE) || (state == ST_GAP);
      done   = (state == ST_END);
   end

endmodule

// File: tb/tb_xgs_tpg_multilane.sv
// Directed and randomized frames checked against a pixel-sequence model.
module tb_xgs_tpg_multilane;

   localparam int NL  = 4;
   localparam int PW  = 12;
   localparam int LCW = 12;
   localparam int DW  = NL*PW;

   logic           sclk = 1'b0;
   logic           srst;
   logic           start;
   logic           abort;
   logic [1:0]     mode;
   logic [PW-1:0]  seed;
   logic [LCW-1:0] line_beats;
   logic [LCW-1:0] frame_lines;
   logic [7:0]     gap_cycles;
   logic           tvalid;
   logic           tready;
   logic [DW-1:0]  tdata;
   logic           tuser;
   logic           tlast;
   logic           busy;
   logic           done;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [DW-1:0] data;
      logic          user;
      logic          last;
   } beat_t;

   beat_t exp_q[$];

   xgs_tpg_multilane #(
      .NUM_LANES      (NL),
      .PIXEL_WIDTH    (PW),
      .LINE_CNT_WIDTH (LCW)
   ) dut (
      .sclk        (sclk),
      .srst        (srst),
      .start       (start),
      .abort       (abort),
      .mode        (mode),
      .seed        (seed),
      .line_beats  (line_beats),
      .frame_lines (frame_lines),
      .gap_cycles  (gap_cycles),
      .tvalid      (tvalid),
      .tready      (tready),
      .tdata       (tdata),
      .tuser       (tuser),
      .tlast       (tlast),
      .busy        (busy),
      .done        (done)
   );

   always #5 sclk = ~sclk;

   task automatic tick();
      @(posedge sclk);
      #1;
   endtask

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Fibonacci LFSR with taps listed as polynomial exponents
   function automatic logic [PW-1:0] lfsr_step(input logic [PW-1:0] s);
      int  tp[4];
      logic fb;
      case (PW)
         8:  tp = '{8, 6, 5, 4};
         9:  tp = '{9, 5, 0, 0};
         10: tp = '{10, 7, 0, 0};
         11: tp = '{11, 9, 0, 0};
         12: tp = '{12, 6, 4, 1};
         13: tp = '{13, 4, 3, 1};
         14: tp = '{14, 5, 3, 1};
         15: tp = '{15, 14, 0, 0};
         default: tp = '{16, 15, 13, 4};
      endcase
      fb = 1'b0;
      for (int i = 0; i < 4; i++)
         if (tp[i] != 0) fb ^= s[tp[i]-1];
      return {s[PW-2:0], fb};
   endfunction

   task automatic build(input int md, input int sd, input int lb, input int fl);
      logic [PW-1:0] s;
      logic [PW-1:0] v;
      beat_t         bt;
      int            b;
      int            e;
      exp_q.delete();
      s = (PW'(sd) == '0) ? '1 : PW'(sd);
      b = 0;
      for (int l = 0; l <= fl; l++) begin
         for (int j = 0; j <= lb; j++) begin
            bt.data = '0;
            for (int k = 0; k < NL; k++) begin
               e = b*NL + k;
               case (md)
                  0:       v = PW'(sd + e);
                  1:       v = PW'(sd);
                  2:       v = PW'(1) << (e % PW);
                  default: begin v = s; s = lfsr_step(s); end
               endcase
               bt.data[k*PW +: PW] = v;
            end
            bt.user = (l == 0) && (j == 0);
            bt.last = (j == lb);
            exp_q.push_back(bt);
            b++;
         end
      end
   endtask

   task automatic run_frame(input int md, input int sd, input int lb, input int fl, input int gp,
                            input int rdy_pct, input int abort_beat, input bit abort_with_start,
                            input int busy_start_cyc);
      int            total;
      int            nx;
      int            last_cyc;
      int            abort_cyc;
      int            idle_run;
      bit            in_gap;
      bit            stall;
      bit            aborted;
      bit            fin;
      beat_t         eb;
      logic [DW-1:0] h_data;
      logic          h_user;
      logic          h_last;
      build(md, sd, lb, fl);
      total = (lb+1)*(fl+1);
      nx = 0; last_cyc = -1; abort_cyc = -1; idle_run = 0;
      in_gap = 0; stall = 0; aborted = 0; fin = 0;
      h_data = '0; h_user = 0; h_last = 0;
      mode = 2'(md); seed = PW'(sd); line_beats = LCW'(lb);
      frame_lines = LCW'(fl); gap_cycles = 8'(gp);
      start = 1'b1; abort = abort_with_start;
      tick();
      start = 1'b0; abort = 1'b0;
      check("first_tvalid", tvalid, 1'b1);
      check("busy_rise", busy, 1'b1);
      // configuration must have been captured at start
      mode = 2'($urandom); seed = PW'($urandom); line_beats = LCW'($urandom);
      frame_lines = LCW'($urandom); gap_cycles = 8'($urandom);
      for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
         tready = ($urandom_range(0, 99) < rdy_pct);
         if (cyc == busy_start_cyc) start = 1'b1;
         if (done) begin
            check("done_busy_low", busy, 1'b0);
            check("done_tvalid_low", tvalid, 1'b0);
            if (aborted) check("abort_done_lat", cyc, abort_cyc + 1);
            else begin
               check("beat_count", nx, total);
               check("done_lat", cyc, last_cyc + 1);
            end
            fin = 1;
         end else if (tvalid) begin
            if (in_gap) begin
               check("gap_len", idle_run, gp);
               in_gap = 0;
            end
            if (stall) begin
               check("hold_tdata", tdata, h_data);
               check("hold_tuser", tuser, h_user);
               check("hold_tlast", tlast, h_last);
            end
            if (abort_beat >= 0 && nx == abort_beat && !aborted) begin
               abort = 1'b1; tready = 1'b0; aborted = 1; abort_cyc = cyc;
            end
            if (tready) begin
               if (exp_q.size() == 0) check("beat_overflow", nx, total - 1);
               else begin
                  eb = exp_q.pop_front();
                  check("tdata", tdata, eb.data);
                  check("tuser", tuser, eb.user);
                  check("tlast", tlast, eb.last);
                  nx++;
                  last_cyc = cyc;
                  if (eb.last && exp_q.size() != 0) begin
                     in_gap = 1; idle_run = 0;
                  end
               end
            end
            stall = !tready;
            h_data = tdata; h_user = tuser; h_last = tlast;
         end else begin
            if (in_gap) begin
               idle_run++;
               check("busy_gap", busy, 1'b1);
            end
            stall = 0;
         end
         tick();
         start = 1'b0; abort = 1'b0;
      end
      check("frame_done", fin, 1'b1);
      check("done_single", done, 1'b0);
      check("idle_busy", busy, 1'b0);
   endtask

   initial begin
      srst = 1'b1; start = 1'b0; abort = 1'b0; mode = '0; seed = '0;
      line_beats = '0; frame_lines = '0; gap_cycles = '0; tready = 1'b1;
      repeat (3) tick();
      check("rst_tvalid", tvalid, 1'b0);
      check("rst_tdata", tdata, '0);
      check("rst_tuser", tuser, 1'b0);
      check("rst_tlast", tlast, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      srst = 1'b0;
      tick();

      // abort while idle does nothing
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("idle_abort_tvalid", tvalid, 1'b0);
      check("idle_abort_busy", busy, 1'b0);
      check("idle_abort_done", done, 1'b0);
      tick();
      check("idle_abort_done2", done, 1'b0);

      run_frame(0, 0, 3, 1, 2, 100, -1, 0, -1);
      run_frame(0, 'hFFE, 2, 1, 0, 100, -1, 0, -1);
      run_frame(0, 0, 3, 1, 2, 50, -1, 0, -1);
      run_frame(1, int'($urandom_range(0, 4095)), 2, 2, 1, 70, -1, 0, -1);
      run_frame(2, 0, 4, 2, 3, 60, -1, 0, -1);
      run_frame(3, 0, 3, 1, 1, 100, -1, 0, -1);
      run_frame(3, int'($urandom_range(1, 4095)), 5, 2, 0, 50, -1, 0, -1);

      // abort on line 1 beat 2, then a full frame afterwards
      run_frame(0, 0, 3, 2, 1, 100, 6, 0, -1);
      run_frame(0, 0, 3, 1, 2, 100, -1, 0, -1);

      run_frame(2, 'h3C, 2, 1, 2, 100, -1, 1, -1);
      run_frame(3, 'h5A5, 5, 2, 3, 100, -1, 0, 4);

      // reset in the middle of a frame
      mode = 2'd0; seed = PW'('h123); line_beats = LCW'(4); frame_lines = LCW'(2);
      gap_cycles = 8'd2; tready = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (5) tick();
      srst = 1'b1;
      tick();
      check("mid_rst_tvalid", tvalid, 1'b0);
      check("mid_rst_tdata", tdata, '0);
      check("mid_rst_tuser", tuser, 1'b0);
      check("mid_rst_tlast", tlast, 1'b0);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_done", done, 1'b0);
      tick();
      check("mid_rst_hold", busy, 1'b0);
      srst = 1'b0;
      tick();
      run_frame(0, 'h123, 4, 2, 2, 100, -1, 0, -1);

      for (int r = 0; r < 6; r++)
         run_frame(int'($urandom_range(0, 3)), int'($urandom_range(0, 4095)),
                   int'($urandom_range(0, 5)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 4)), int'($urandom_range(30, 100)), -1, 0, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
